// File: rtl/rom_load_ctl.sv
// ROM download controller: steers the HPS byte stream into four ROM regions,
// checks the load for completeness and order, then sequences the core reset.
module rom_load_ctl #(
  parameter int CPU_SIZE  = 32768,
  parameter int TILE_SIZE = 24576,
  parameter int SPR_SIZE  = 32768,
  parameter int SND_SIZE  = 8192,
  parameter int HOLD_CYC  = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [3:0]  rom_we,
  output logic        core_rst,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] cksum,
  output logic [2:0]  dbg_state
);

  localparam int TOTAL_I = CPU_SIZE + TILE_SIZE + SPR_SIZE + SND_SIZE;
  localparam logic [24:0] BASE1 = 25'(CPU_SIZE);
  localparam logic [24:0] BASE2 = 25'(CPU_SIZE + TILE_SIZE);
  localparam logic [24:0] BASE3 = 25'(CPU_SIZE + TILE_SIZE + SPR_SIZE);
  localparam logic [24:0] TOTAL = 25'(TOTAL_I);
  localparam int CW  = ($clog2(TOTAL_I + 1) > 18) ? $clog2(TOTAL_I + 1) : 18;
  localparam int HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t          state, state_n;
  logic            dl_prev;
  logic [CW-1:0]   byte_cnt;
  logic [24:0]     exp_addr;
  logic            err_flag;
  logic [HCW-1:0]  hold_cnt;

  logic            dl_rise, dl_fall;
  logic            wr_in_load, accept, reject, check_pass;
  logic [3:0]      region_we;
  logic [15:0]     region_off;

  assign dl_rise    = ioctl_download & ~dl_prev;
  assign dl_fall    = ~ioctl_download & dl_prev;
  // A strobe in the same cycle as the download edge belongs to no load.
  assign wr_in_load = (state == S_LOAD) && !dl_rise && ioctl_wr;
  assign accept     = wr_in_load && (ioctl_addr == exp_addr) && (ioctl_addr < TOTAL);
  assign reject     = wr_in_load && !((ioctl_addr == exp_addr) && (ioctl_addr < TOTAL));
  assign check_pass = (byte_cnt == CW'(TOTAL_I)) && !err_flag;

  assign core_rst   = (state != S_RUN);
  assign dbg_state  = state;

  // Region boundaries are inclusive at the base, so a boundary byte falls upward.
  always_comb begin
    region_we  = 4'b0001;
    region_off = ioctl_addr[15:0];
    if (ioctl_addr >= BASE3) begin
      region_we  = 4'b1000;
      region_off = ioctl_addr[15:0] - BASE3[15:0];
    end else if (ioctl_addr >= BASE2) begin
      region_we  = 4'b0100;
      region_off = ioctl_addr[15:0] - BASE2[15:0];
    end else if (ioctl_addr >= BASE1) begin
      region_we  = 4'b0010;
      region_off = ioctl_addr[15:0] - BASE1[15:0];
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = S_IDLE;
      S_LOAD:  if (dl_fall) state_n = S_CHECK;
      S_CHECK: state_n = check_pass ? S_HOLD : S_ERR;
      S_HOLD:  if (hold_cnt == HCW'(HOLD_CYC - 1)) state_n = S_RUN;
      S_RUN:   state_n = S_RUN;
      S_ERR:   state_n = S_ERR;
      default: state_n = S_IDLE;
    endcase
    if (dl_rise) state_n = S_LOAD;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      // Tracking the pin through reset keeps an ongoing download from looking like a new edge.
      dl_prev   <= ioctl_download;
      byte_cnt  <= '0;
      exp_addr  <= '0;
      err_flag  <= 1'b0;
      cksum     <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      hold_cnt  <= '0;
      rom_we    <= '0;
      rom_addr  <= '0;
      rom_data  <= '0;
    end else begin
      dl_prev <= ioctl_download;
      rom_we  <= accept ? region_we : 4'b0000;
      if (accept) begin
        rom_addr <= region_off;
        rom_data <= ioctl_dout;
        exp_addr <= exp_addr + 25'd1;
        cksum    <= cksum + {8'h00, ioctl_dout};
        if (byte_cnt != '1) byte_cnt <= byte_cnt + CW'(1);
      end
      if (reject) err_flag <= 1'b1;
      if (state == S_CHECK) begin
        hold_cnt <= '0;
        if (check_pass) load_done <= 1'b1;
        else            load_err  <= 1'b1;
      end
      if (state == S_HOLD) hold_cnt <= hold_cnt + HCW'(1);
      if (dl_rise) begin
        byte_cnt  <= '0;
        exp_addr  <= '0;
        err_flag  <= 1'b0;
        cksum     <= '0;
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end
    end
  end

endmodule
